// File: rtl/pll_lock_supervisor.sv
// PLL power-up/recovery sequencer: holds the PLL in reset, qualifies the
// synchronized lock flag, retries on timeout and tracks lock losses.
module pll_lock_supervisor #(
    parameter int unsigned RST_HOLD_CYCLES    = 500,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1000,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned CNT_W               = 8
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             restart,
    input  logic             clr_loss_cnt,
    output logic             pll_rst,
    output logic             pll_ready,
    output logic             pll_fail,
    output logic             lock_lost,
    output logic [CNT_W-1:0] lock_loss_cnt,
    output logic [2:0]       state_o
);

    localparam int unsigned MAX_AB = (RST_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                     RST_HOLD_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned MAX_P  = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
    localparam int unsigned TMR_W  = (MAX_P > 1) ? $clog2(MAX_P) : 1;
    localparam int unsigned RTY_W  = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [TMR_W-1:0] RST_LAST     = TMR_W'(RST_HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE      = TMR_W'(1);
    localparam logic [RTY_W-1:0] RTY_MAX      = RTY_W'(MAX_RETRIES);
    localparam logic [RTY_W-1:0] RTY_ONE      = RTY_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    typedef enum logic [2:0] {
        RESET_HOLD = 3'd0,
        WAIT_LOCK  = 3'd1,
        STABILIZE  = 3'd2,
        READY      = 3'd3,
        FAILED     = 3'd4
    } state_t;

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic [RTY_W-1:0] retry_cnt;
    logic             sync_ff;
    logic             locked_s;

    assign state_o = state;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff  <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync_ff  <= pll_locked;
            locked_s <= sync_ff;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RESET_HOLD;
            timer         <= '0;
            retry_cnt     <= '0;
            pll_rst       <= 1'b1;
            pll_ready     <= 1'b0;
            pll_fail      <= 1'b0;
            lock_lost     <= 1'b0;
            lock_loss_cnt <= '0;
        end else begin
            lock_lost <= 1'b0;
            timer     <= timer + TMR_ONE;
            if (restart) begin
                state     <= RESET_HOLD;
                timer     <= '0;
                retry_cnt <= '0;
                pll_rst   <= 1'b1;
                pll_ready <= 1'b0;
                pll_fail  <= 1'b0;
            end else begin
                unique case (state)
                    RESET_HOLD: begin
                        if (timer == RST_LAST) begin
                            state   <= WAIT_LOCK;
                            timer   <= '0;
                            pll_rst <= 1'b0;
                        end
                    end
                    WAIT_LOCK: begin
                        if (locked_s) begin
                            state <= STABILIZE;
                            timer <= '0;
                        end else if (timer == TIMEOUT_LAST) begin
                            timer   <= '0;
                            pll_rst <= 1'b1;
                            if (retry_cnt == RTY_MAX) begin
                                state    <= FAILED;
                                pll_fail <= 1'b1;
                            end else begin
                                state     <= RESET_HOLD;
                                retry_cnt <= retry_cnt + RTY_ONE;
                            end
                        end
                    end
                    STABILIZE: begin
                        if (!locked_s) begin
                            state <= WAIT_LOCK;
                            timer <= '0;
                        end else if (timer == STABLE_LAST) begin
                            state     <= READY;
                            timer     <= '0;
                            retry_cnt <= '0;
                            pll_ready <= 1'b1;
                        end
                    end
                    READY: begin
                        if (!locked_s) begin
                            state     <= RESET_HOLD;
                            timer     <= '0;
                            pll_rst   <= 1'b1;
                            pll_ready <= 1'b0;
                            lock_lost <= 1'b1;
                            if (lock_loss_cnt != '1) begin
                                lock_loss_cnt <= lock_loss_cnt + CNT_ONE;
                            end
                        end
                    end
                    FAILED: begin
                    end
                    default: begin
                        state     <= RESET_HOLD;
                        timer     <= '0;
                        pll_rst   <= 1'b1;
                        pll_ready <= 1'b0;
                        pll_fail  <= 1'b0;
                    end
                endcase
            end
            // Placed last so a coincident clear overrides the READY increment.
            if (clr_loss_cnt) begin
                lock_loss_cnt <= '0;
            end
        end
    end

endmodule
